// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared state encoding and width helper for the run controller
// Ports: none (package).
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - register-file debug port plus dump stream
// Ports (signals): dbg_addr/dbg_rdata (debug read), dump_valid/dump_ready/dump_idx/dump_data (stream).
// master = controller side, slave = CPU register file / dump consumer side.
interface cpu_run_controller_if #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
);

  logic [IDX_W-1:0]  dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dbg_addr,
    input  dbg_rdata,
    output dump_valid,
    input  dump_ready,
    output dump_idx,
    output dump_data
  );

  modport slave (
    input  dbg_addr,
    output dbg_rdata,
    input  dump_valid,
    output dump_ready,
    input  dump_idx,
    input  dump_data
  );

endinterface

// File: rtl/dump_streamer.sv
// rtl/dump_streamer.sv - walks the register file and streams it out as valid/ready beats
// Ports: clk, reset (sync, active-high), active (controller is in DUMP),
//   bus (master: dbg_addr/dbg_rdata, dump_*), load (a beat is captured this cycle),
//   ptr (register currently addressed), last_accept (final beat accepted this cycle).
module dump_streamer
  import cpu_run_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  cpu_run_controller_if.master bus,
  output logic             load,
  output logic [IDX_W-1:0] ptr,
  output logic             last_accept
);

  // Set once the last register has been captured; from then on the slice only drains.
  logic all_loaded;

  always_comb begin
    load        = active && !all_loaded && (!bus.dump_valid || bus.dump_ready);
    last_accept = active && all_loaded && bus.dump_valid && bus.dump_ready;
  end

  assign bus.dbg_addr = ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr            <= '0;
      all_loaded     <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.dump_idx   <= '0;
      bus.dump_data  <= '0;
    end else if (load) begin
      bus.dump_data  <= bus.dbg_rdata;
      bus.dump_idx   <= ptr;
      bus.dump_valid <= 1'b1;
      ptr            <= ptr + IDX_W'(1);
      if (ptr == IDX_W'(NUM_REGS - 1)) begin
        all_loaded <= 1'b1;
      end
    end else if (last_accept) begin
      bus.dump_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - hold/run/dump/done sequencer wrapped around a CPU core
// Ports: clk, reset (sync, active-high), cpu_reset (to core), cpu_halt (from core),
//   bus (master: register-file debug port and dump stream), cycles (RUN cycle count),
//   done, timed_out, pass (status, sticky until reset).
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int              RESET_CYCLES   = 3,
  parameter int              TIMEOUT_CYCLES = 10000,
  parameter int              NUM_REGS       = 32,
  parameter int              DATA_W         = 32,
  parameter int              CHECK_REG      = 2,
  parameter logic [DATA_W-1:0] CHECK_VALUE  = '0,
  localparam int             CNT_W          = width_for(TIMEOUT_CYCLES + 1),
  localparam int             IDX_W          = width_for(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             cpu_reset,
  input  logic             cpu_halt,
  cpu_run_controller_if.master bus,
  output logic [CNT_W-1:0] cycles,
  output logic             done,
  output logic             timed_out,
  output logic             pass
);

  localparam int HOLD_W = width_for(RESET_CYCLES);

  run_state_t        state, state_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_last;
  logic              budget_hit;
  logic              chk_ok;
  logic              load;
  logic [IDX_W-1:0]  ptr;
  logic              last_accept;

  dump_streamer #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_streamer (
    .clk         (clk),
    .reset       (reset),
    .active      (state == ST_DUMP),
    .bus         (bus),
    .load        (load),
    .ptr         (ptr),
    .last_accept (last_accept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_HOLD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    hold_last  = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
    budget_hit = (cycles == CNT_W'(TIMEOUT_CYCLES - 1));
    state_nx   = state;
    case (state)
      ST_HOLD: if (hold_last) state_nx = ST_RUN;
      ST_RUN:  if (cpu_halt || budget_hit) state_nx = ST_DUMP;
      ST_DUMP: if (last_accept) state_nx = ST_DONE;
      default: state_nx = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      cpu_reset <= 1'b1;
      cycles    <= '0;
      timed_out <= 1'b0;
      chk_ok    <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_last) cpu_reset <= 1'b0;
          else           hold_cnt  <= hold_cnt + HOLD_W'(1);
        end
        ST_RUN: begin
          // Halt takes priority over budget expiry; the count only advances
          // while the run continues, so it tops out at TIMEOUT_CYCLES-1.
          if (cpu_halt) begin
            cpu_reset <= 1'b1;
            timed_out <= 1'b0;
          end else if (budget_hit) begin
            cpu_reset <= 1'b1;
            timed_out <= 1'b1;
          end else begin
            cycles <= cycles + CNT_W'(1);
          end
        end
        ST_DUMP: begin
          if (load && (ptr == IDX_W'(CHECK_REG))) begin
            chk_ok <= (bus.dbg_rdata == CHECK_VALUE);
          end
          if (last_accept) begin
            done <= 1'b1;
            pass <= !timed_out && chk_ok;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
